// File: rtl/predictor_pkg.sv
// Shared definitions for the gshare fetch predictor.
// Provides the 2-bit counter encodings, the saturating counter update and
// default table sizes used by gshare_fetch_predictor and btb_dm.
package predictor_pkg;

    localparam int unsigned GHR_BITS_DEF     = 8;
    localparam int unsigned BTB_IDX_BITS_DEF = 4;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Saturating 2-bit counter step towards the resolved outcome.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end else begin
            res = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer.
// Ports:
//   clk, reset            clock and synchronous active-high reset (clears valid bits only)
//   lookup_pc             fetch PC to look up
//   hit, target           entry valid with matching tag, and its stored target
//   wr_en, wr_pc,
//   wr_target             install/overwrite the entry for wr_pc
// Lookups see registered state only, so a same-cycle write is visible next cycle.
module btb_dm #(
    parameter int unsigned IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic [31:0] target,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_target
);

    localparam int unsigned ENTRIES  = 2 ** IDX_BITS;
    localparam int unsigned TAG_BITS = 30 - IDX_BITS;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic [IDX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0] wr_tag;

    // Instructions are word aligned; the low PC bits carry no information.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{lookup_pc[1:0], wr_pc[1:0]};

    assign lk_idx = lookup_pc[IDX_BITS+1:2];
    assign lk_tag = lookup_pc[31:IDX_BITS+2];
    assign wr_idx = wr_pc[IDX_BITS+1:2];
    assign wr_tag = wr_pc[31:IDX_BITS+2];

    assign hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign target = target_q[lk_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is never used while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/gshare_fetch_predictor.sv
// Fetch-stage PC generator with gshare direction prediction and a direct-mapped BTB.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   stall_F         hold PC_F
//   PC_F            registered fetch PC
//   PredTaken_F     taken prediction for PC_F
//   PHTIdx_F        PHT index used for PC_F, carried down the pipe to E
//   Resolve_E, PC_E, PHTIdx_E, Taken_E, Target_E   branch resolution / training
//   Redirect_E, CorrectPC_E                        misprediction restart
//   BranchCnt, MispredCnt   statistics, present only when PRED_STATS_EN is defined
// Optional feature macro: PRED_STATS_EN.
module gshare_fetch_predictor
    import predictor_pkg::*;
#(
    parameter int unsigned GHR_BITS     = GHR_BITS_DEF,
    parameter int unsigned BTB_IDX_BITS = BTB_IDX_BITS_DEF,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_F,
    output logic [31:0]         PC_F,
    output logic                PredTaken_F,
    output logic [GHR_BITS-1:0] PHTIdx_F,
    input  logic                Resolve_E,
    input  logic [31:0]         PC_E,
    input  logic [GHR_BITS-1:0] PHTIdx_E,
    input  logic                Taken_E,
    input  logic [31:0]         Target_E,
    input  logic                Redirect_E,
    input  logic [31:0]         CorrectPC_E
`ifdef PRED_STATS_EN
    ,
    output logic [31:0]         BranchCnt,
    output logic [31:0]         MispredCnt
`endif
);

    localparam int unsigned PHT_SIZE = 2 ** GHR_BITS;

    logic [31:0]         pc_q;
    logic [31:0]         pc_d;
    logic [GHR_BITS-1:0] ghr_q;
    logic [1:0]          pht_q [PHT_SIZE];

    logic                btb_hit;
    logic [31:0]         btb_target;
    logic [31:0]         pred_next;

    btb_dm #(
        .IDX_BITS (BTB_IDX_BITS)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .lookup_pc (pc_q),
        .hit       (btb_hit),
        .target    (btb_target),
        .wr_en     (Resolve_E && Taken_E),
        .wr_pc     (PC_E),
        .wr_target (Target_E)
    );

    assign PC_F        = pc_q;
    assign PHTIdx_F    = pc_q[GHR_BITS+1:2] ^ ghr_q;
    // Only redirect to a target we actually know; a taken counter without a BTB hit falls through.
    assign PredTaken_F = pht_q[PHTIdx_F][1] && btb_hit;
    assign pred_next   = PredTaken_F ? btb_target : pc_q + 32'd4;

    always_comb begin
        pc_d = pred_next;
        if (Redirect_E) begin
            pc_d = CorrectPC_E;
        end else if (stall_F) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            ghr_q <= '0;
            for (int unsigned i = 0; i < PHT_SIZE; i++) begin
                pht_q[i] <= CNT_WNT;
            end
        end else begin
            pc_q <= pc_d;
            // Training is from resolved outcomes only, independent of stall.
            if (Resolve_E) begin
                pht_q[PHTIdx_E] <= sat_update(pht_q[PHTIdx_E], Taken_E);
                ghr_q           <= {ghr_q[GHR_BITS-2:0], Taken_E};
            end
        end
    end

`ifdef PRED_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (Resolve_E && (branch_cnt_q != 32'hFFFF_FFFF)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (Resolve_E && Redirect_E && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign BranchCnt  = branch_cnt_q;
    assign MispredCnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_gshare_fetch_predictor.sv
module tb_gshare_fetch_predictor;

    logic        clk;
    logic        reset;
    logic        stall_F;
    logic [31:0] PC_F;
    logic        PredTaken_F;
    logic [7:0]  PHTIdx_F;
    logic        Resolve_E;
    logic [31:0] PC_E;
    logic [7:0]  PHTIdx_E;
    logic        Taken_E;
    logic [31:0] Target_E;
    logic        Redirect_E;
    logic [31:0] CorrectPC_E;
`ifdef PRED_STATS_EN
    logic [31:0] BranchCnt;
    logic [31:0] MispredCnt;
`endif

    gshare_fetch_predictor #(
        .GHR_BITS     (8),
        .BTB_IDX_BITS (4),
        .RESET_PC     (32'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_F     (stall_F),
        .PC_F        (PC_F),
        .PredTaken_F (PredTaken_F),
        .PHTIdx_F    (PHTIdx_F),
        .Resolve_E   (Resolve_E),
        .PC_E        (PC_E),
        .PHTIdx_E    (PHTIdx_E),
        .Taken_E     (Taken_E),
        .Target_E    (Target_E),
        .Redirect_E  (Redirect_E),
        .CorrectPC_E (CorrectPC_E)
`ifdef PRED_STATS_EN
        ,
        .BranchCnt   (BranchCnt),
        .MispredCnt  (MispredCnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        rst;
        logic        st;
        logic        rs;
        logic [31:0] pce;
        logic [7:0]  idxe;
        logic        tk;
        logic [31:0] tgt;
        logic        rd;
        logic [31:0] cpc;
        logic [31:0] epc;
        logic        ept;
        logic [7:0]  eidx;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[9];
    int   checks;
    int   failures;

    function automatic vec_t mk(input string n, input logic rst, input logic st, input logic rs,
                                input logic [31:0] pce, input logic [7:0] idxe, input logic tk,
                                input logic [31:0] tgt, input logic rd, input logic [31:0] cpc,
                                input logic [31:0] epc, input logic ept, input logic [7:0] eidx);
        vec_t v;
        v.name = n;  v.rst = rst; v.st = st;   v.rs = rs;   v.pce = pce; v.idxe = idxe;
        v.tk = tk;   v.tgt = tgt; v.rd = rd;   v.cpc = cpc; v.epc = epc; v.ept = ept;
        v.eidx = eidx;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        vec_t e;
        reset       = v.rst;
        stall_F     = v.st;
        Resolve_E   = v.rs;
        PC_E        = v.pce;
        PHTIdx_E    = v.idxe;
        Taken_E     = v.tk;
        Target_E    = v.tgt;
        Redirect_E  = v.rd;
        CorrectPC_E = v.cpc;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.name, "_pc"}, PC_F, e.epc);
        chk({e.name, "_pt"}, {31'b0, PredTaken_F}, {31'b0, e.ept});
        chk({e.name, "_idx"}, {24'b0, PHTIdx_F}, {24'b0, e.eidx});
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; stall_F = 1'b0; Resolve_E = 1'b0; PC_E = '0; PHTIdx_E = '0;
        Taken_E = 1'b0; Target_E = '0; Redirect_E = 1'b0; CorrectPC_E = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", PC_F, 32'h0);
        chk("reset_pt", {31'b0, PredTaken_F}, 32'h0);
        chk("reset_idx", {24'b0, PHTIdx_F}, 32'h0);

        // Sequential fetch, then a 4-cycle stall at 0x10 and release.
        tbl[0] = mk("seq1",   0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h04, 0, 8'h01);
        tbl[1] = mk("seq2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h08, 0, 8'h02);
        tbl[2] = mk("seq3",   0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0C, 0, 8'h03);
        tbl[3] = mk("seq4",   0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 8'h04);
        tbl[4] = mk("stall1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 8'h04);
        tbl[5] = mk("stall2", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 8'h04);
        tbl[6] = mk("stall3", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 8'h04);
        tbl[7] = mk("stall4", 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 8'h04);
        tbl[8] = mk("release",0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h14, 0, 8'h05);
        for (int i = 0; i < 9; i++) apply(tbl[i]);

        // Train branch at 0x20 taken to 0x100 while fetch is parked on it.
        apply(mk("goto20",  0, 0, 0, 0, 0, 0, 0, 1, 32'h20, 32'h20, 0, 8'h08));
        apply(mk("train1",  0, 1, 1, 32'h20, 8'h0B, 1, 32'h100, 0, 0, 32'h20, 0, 8'h09));
        apply(mk("train2",  0, 1, 1, 32'h20, 8'h0B, 1, 32'h100, 0, 0, 32'h20, 1, 8'h0B));
        apply(mk("predtgt", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 8'h43));
        apply(mk("rdstall", 0, 1, 0, 0, 0, 0, 0, 1, 32'h200, 32'h200, 0, 8'h83));
        apply(mk("back20",  0, 1, 0, 0, 0, 0, 0, 1, 32'h20, 32'h20, 1, 8'h0B));

        // Four not-taken resolves on 0x0B: counter 11->10->01->00->00, GHR shifts in 0s.
        apply(mk("nt1", 0, 1, 1, 32'h20, 8'h0B, 0, 0, 0, 0, 32'h20, 0, 8'h0E));
        apply(mk("nt2", 0, 1, 1, 32'h20, 8'h0B, 0, 0, 0, 0, 32'h20, 0, 8'h04));
        apply(mk("nt3", 0, 1, 1, 32'h20, 8'h0B, 0, 0, 0, 0, 32'h20, 0, 8'h10));
        apply(mk("nt4", 0, 1, 1, 32'h20, 8'h0B, 0, 0, 0, 0, 32'h20, 0, 8'h38));
        // One taken step from a saturated 00 must give 01 (not taken); installs 0x1A8 in BTB.
        apply(mk("probe",  0, 1, 1, 32'h1A8, 8'h0B, 1, 32'h300, 0, 0, 32'h20, 0, 8'h69));
        apply(mk("look",   0, 1, 0, 0, 0, 0, 0, 1, 32'h1A8, 32'h1A8, 0, 8'h0B));
        apply(mk("fall",   0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1AC, 0, 8'h0A));

        // Reset mid-operation with resolve and redirect active: both must be ignored.
        apply(mk("midrst", 1, 0, 1, 32'h20, 8'h0B, 1, 32'h100, 1, 32'h400, 32'h0, 0, 8'h00));
        apply(mk("postrst",0, 1, 0, 0, 0, 0, 0, 1, 32'h20, 32'h20, 0, 8'h08));

`ifdef PRED_STATS_EN
        chk("stats_branch_rst", BranchCnt, 32'd0);
        chk("stats_mispred_rst", MispredCnt, 32'd0);
        for (int i = 0; i < 5; i++) begin
            stall_F = 1'b1; Resolve_E = 1'b1; Taken_E = 1'b0; PC_E = 32'h20;
            PHTIdx_E = 8'h08; Redirect_E = (i < 2); CorrectPC_E = 32'h24;
            @(posedge clk);
            #1;
        end
        Resolve_E = 1'b0; Redirect_E = 1'b0;
        @(posedge clk);
        #1;
        chk("stats_branch", BranchCnt, 32'd5);
        chk("stats_mispred", MispredCnt, 32'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("stats_branch_clr", BranchCnt, 32'd0);
        chk("stats_mispred_clr", MispredCnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
